// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial adder: one shared 1-bit full-adder cell adds two WIDTH-bit
//   operands plus a carry-in, LSB first, one bit per clock.
// Ports
//   clk    : clock, all state changes on the rising edge
//   rst_n  : asynchronous active-low reset
//   start  : begin an addition (accepted only while idle)
//   a, b   : addends, captured when start is accepted
//   cin    : carry-in, captured when start is accepted
//   busy   : high while bits are being processed
//   done   : one-cycle pulse when sum/cout hold the final result
//   sum    : result, held until the next accepted start
//   cout   : carry-out, held with sum
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter must hold WIDTH itself, so it never wraps on the last bit.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_r;
  logic [1:0]       state_next_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_shift_s;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic             cout_r;
  logic             busy_r;
  logic             done_r;
  logic [1:0]       fa_s;
  logic             last_bit_s;

  // The single full-adder cell; returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    logic s;
    logic co;
    s  = x ^ y ^ c;
    co = (x & y) | ((x ^ y) & c);
    return {co, s};
  endfunction

  // Adder datapath: operand shift registers present the current bit at index 0.
  always_comb begin
    fa_s        = full_add(a_r[0], b_r[0], carry_r);
    sum_shift_s = sum_r >> 1;
    sum_shift_s[WIDTH-1] = fa_s[0];
    last_bit_s  = (cnt_r == LAST_BIT);
  end

  // Next-state logic for the IDLE/ADD/DONE controller.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = ADD;
        else       state_next_s = IDLE;
      end
      ADD: begin
        if (last_bit_s) state_next_s = DONE;
        else            state_next_s = ADD;
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, status flags and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      cnt_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ADD: begin
          a_r     <= a_r >> 1;
          b_r     <= b_r >> 1;
          sum_r   <= sum_shift_s;
          carry_r <= fa_s[1];
          cnt_r   <= cnt_r + CNT_ONE;
          if (last_bit_s) begin
            cout_r <= fa_s[1];
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            busy_r <= 1'b1;
            done_r <= 1'b0;
          end
        end
        DONE: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl (WIDTH=8): directed vector table, corner
// sequences (late start, mid-operation reset, held start) and random ops
// compared against plain integer addition.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int total;
  int bad;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vcin;
    logic         scramble;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the operands presented at acceptance.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // One complete operation starting from an idle cycle (called at a negedge).
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                        input logic scramble, input logic [W-1:0] es, input logic ec,
                        input string tag);
    int busy_cnt;
    busy_cnt = 0;
    start = 1'b1; a = va; b = vb; cin = vc;
    @(posedge clk);
    #1 start = 1'b0;
    for (int j = 1; j <= W; j++) begin
      @(negedge clk);
      if (busy === 1'b1 && done === 1'b0) busy_cnt++;
      if (scramble) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
    end
    chk({tag, "_busy_cycles"}, busy_cnt, W);
    @(negedge clk);
    chk({tag, "_done"}, {busy, done}, 2'b01);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    @(negedge clk);
    chk({tag, "_idle"}, {busy, done}, 2'b00);
    chk({tag, "_sum_held"}, {cout, sum}, {ec, es});
  endtask

  initial begin
    logic [W:0]   r;
    logic [W-1:0] ra, rb;
    logic         rc;
    int           done_cnt;

    total = 0; bad = 0;
    rst_n = 1'b0; start = 1'b1; a = '1; b = '1; cin = 1'b1;

    vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[1] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0};
    vecs[2] = '{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 1'b0};
    vecs[4] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0};
    vecs[5] = '{8'h80, 8'h7F, 1'b1, 1'b1, 8'h00, 1'b1};

    // Reset state with start asserted.
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, cout, sum}, '0);
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", {busy, done}, 2'b00);

    // Directed table.
    foreach (vecs[i])
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].scramble,
             vecs[i].exp_sum, vecs[i].exp_cout, $sformatf("vec%0d", i));

    // Start pulsed with a new operand in ADD cycle 3 must be ignored.
    done_cnt = 0;
    start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    for (int j = 1; j <= W + 3; j++) begin
      @(negedge clk);
      if (j == 3) begin start = 1'b1; a = 8'hFF; end
      else        start = 1'b0;
      if (done === 1'b1) done_cnt++;
      if (j == W + 1) chk("late_start_result", {cout, sum}, {1'b0, 8'h10});
      if (j == W + 3) chk("late_start_no_rerun", {busy, done}, 2'b00);
    end
    chk("late_start_done_pulses", done_cnt, 1);

    // Asynchronous reset in ADD cycle 4: outputs clear at once, no done.
    start = 1'b1; a = 8'h55; b = 8'h66; cin = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1 chk("async_reset_clear", {busy, done, cout, sum}, '0);
    start = 1'b1;
    done_cnt = 0;
    for (int j = 0; j < W + 2; j++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) done_cnt++;
    end
    chk("reset_held_quiet", done_cnt, 0);
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    run_op(8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, "after_reset");

    // Start held high: back-to-back random ops every W+2 cycles, operands
    // changing every cycle so only the acceptance-cycle values count.
    start = 1'b1;
    for (int op = 0; op < 300; op++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      if (op % 50 == 0) begin ra = '1; rb = '1; rc = 1'b1; end
      a = ra; b = rb; cin = rc;
      r = ref_add(ra, rb, rc);
      @(posedge clk);
      done_cnt = 0;
      for (int j = 1; j <= W + 1; j++) begin
        @(negedge clk);
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        if (j <= W && (busy !== 1'b1 || done !== 1'b0)) done_cnt = 99;
        if (done === 1'b1) done_cnt++;
      end
      chk("held_done_cycle", {busy, done}, 2'b01);
      chk("held_result", {cout, sum}, r);
      @(negedge clk);
      chk("held_idle_gap", {busy, done}, 2'b00);
      chk("held_done_pulses", done_cnt, 1);
    end
    start = 1'b0;
    @(negedge clk);
    chk("final_idle", {busy, done}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL provide parameter: WIDTH, default 8, operand width in bits (legal range 1..32).
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port: start  input  1  request to begin one addition; sampled on rising clk.
REQ-005 SHALL provide port: a  input  WIDTH  addend A; sampled only when start is accepted.
REQ-006 SHALL provide port: b  input  WIDTH  addend B; sampled only when start is accepted.
REQ-007 SHALL provide port: cin  input  1  carry-in; sampled only when start is accepted.
REQ-008 SHALL provide port: busy  output  1  high while bit-serial addition is in progress.
REQ-009 SHALL provide port: done  output  1  single-cycle pulse when the result is valid.
REQ-010 SHALL provide port: sum  output  WIDTH  registered result, held until the next accepted start.
REQ-011 SHALL provide port: cout  output  1  registered carry-out, held with sum.

Function
REQ-012 SHALL time-share exactly one 1-bit full-adder cell (s = x^y^c; co = x&y | (x^y)&c), processing one bit per cycle, LSB first.
REQ-013 SHALL implement FSM with states IDLE, ADD, DONE; reset state IDLE.
REQ-014 SHALL accept start only in IDLE: on that edge, latch a, b into shift registers, latch cin into carry register, clear bit counter, go to ADD.
REQ-015 SHALL ignore start in ADD and DONE; latched operands and progress remain unaffected.
REQ-016 SHALL, in each ADD cycle, add operand bits at index = counter plus current carry; shift s into result register from the MSB side; store co into carry register; increment counter.
REQ-017 SHALL leave ADD for DONE on the edge that processes bit WIDTH-1; on that edge sum and cout take final values.
REQ-018 SHALL spend exactly WIDTH cycles in ADD; WIDTH=1 gives one ADD cycle.
REQ-019 SHALL assert busy iff state is ADD; assert done iff state is DONE (exactly one cycle); return DONE -> IDLE unconditionally.
REQ-020 SHALL set latency: start accepted at edge 0 -> done high in the cycle after edge WIDTH+1... precisely, busy high cycles 1..WIDTH, done high cycle WIDTH+1, idle again at cycle WIDTH+2.
REQ-021 SHALL keep sum/cout unchanged in IDLE and DONE; intermediate (partial) values visible during ADD are not valid, and only done qualifies them.
REQ-022 SHALL produce sum = (a + b + cin) mod 2^WIDTH and cout = bit WIDTH of (a + b + cin), using the values latched at acceptance (later input changes have no effect).
REQ-023 SHALL size the bit counter to hold WIDTH without overflow; no wrap-around mid-operation.
REQ-024 SHALL, when start is high in DONE, ignore it; a start held high through DONE is accepted in the following IDLE cycle.

Reset
REQ-025 SHALL, on rst_n low, immediately (asynchronously) force state IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry register=0, operand registers=0.
REQ-026 SHALL abort any in-progress addition on reset with no done pulse; the first start after rst_n deasserts is accepted normally.
REQ-027 SHALL assert no done and no busy while rst_n is low, regardless of start.

Verification (WIDTH=8)
REQ-028 SHALL pass: a=0xFF, b=0x01, cin=0, start one cycle -> busy for 8 cycles, done in cycle 9, sum=0x00, cout=1.
REQ-029 SHALL pass: a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0; a=0xAA, b=0x55, cin=1 -> sum=0x00, cout=1.
REQ-030 SHALL pass: start pulsed at cycle 3 of an operation (a=0x0F, b=0x01) with new a=0xFF -> ignored, result sum=0x10, cout=0, single done pulse.
REQ-031 SHALL pass: a, b, cin changed every cycle after acceptance (a=0x7F, b=0x01, cin=0) -> sum=0x80, cout=0.
REQ-032 SHALL pass: rst_n low at ADD cycle 4 -> all outputs 0 immediately, no done; new start a=0x03, b=0x04 -> sum=0x07 after full latency.
REQ-033 SHALL pass: start held high continuously -> operations repeat every WIDTH+2 cycles, each with exactly one done pulse; exhaustive random compare against a+b+cin.
